// File: rtl/ttt_pkg.sv
// Shared types, board geometry and combinational board helpers for the
// tic-tac-toe turn controller. Board vectors pack cell i at bits [2i+1:2i].
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    PX    = 2'b01,
    PO    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1_WAIT,
    S_P2_WAIT,
    S_COMMIT,
    S_CHECK,
    S_OVER
  } state_t;

  localparam int NCELLS = 9;
  localparam int NLINES = 8;
  localparam int BOARD_W = 2 * NCELLS;

  localparam int LINES [NLINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  function automatic logic has_line(input logic [BOARD_W-1:0] b, input cell_t p);
    logic hit;
    hit = 1'b0;
    for (int l = 0; l < NLINES; l++) begin
      if (b[2*LINES[l][0] +: 2] == p && b[2*LINES[l][1] +: 2] == p &&
          b[2*LINES[l][2] +: 2] == p)
        hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic board_full(input logic [BOARD_W-1:0] b);
    logic full;
    full = 1'b1;
    for (int i = 0; i < NCELLS; i++) begin
      if (b[2*i +: 2] == EMPTY) full = 1'b0;
    end
    return full;
  endfunction

  // Scanning downward leaves the lowest empty index as the final assignment.
  function automatic logic [3:0] lowest_empty(input logic [BOARD_W-1:0] b);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NCELLS - 1; i >= 0; i--) begin
      if (b[2*i +: 2] == EMPTY) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic is_legal(input logic [BOARD_W-1:0] b, input logic [3:0] pos);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NCELLS; i++) begin
      if (pos == 4'(i) && b[2*i +: 2] == EMPTY) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ttt_turn_controller_if.sv
// Move handshake and board/status bundle between the turn controller
// (slave) and its human input, CPU generator and display logic (master).
interface ttt_turn_controller_if;
  import ttt_pkg::*;

  logic               start;
  logic               move_valid;
  logic [3:0]         move_pos;
  logic               cpu_req;
  logic               cpu_valid;
  logic [3:0]         cpu_pos;
  logic [BOARD_W-1:0] board;
  logic [1:0]         turn;
  logic               move_err;
  logic [1:0]         winner;
  logic               game_over;

  modport slave (
    input  start, move_valid, move_pos, cpu_valid, cpu_pos,
    output cpu_req, board, turn, move_err, winner, game_over
  );

  modport master (
    output start, move_valid, move_pos, cpu_valid, cpu_pos,
    input  cpu_req, board, turn, move_err, winner, game_over
  );
endinterface

// File: rtl/ttt_cell.sv
// One board cell: 2-bit register with write enable and a game-start clear.
module ttt_cell
  import ttt_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  clr,
  input  logic  we,
  input  cell_t d,
  output cell_t q
);

  cell_t cell_d, cell_q;

  always_comb begin
    cell_d = cell_q;
    if (clr)     cell_d = EMPTY;
    else if (we) cell_d = d;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) cell_q <= EMPTY;
    else        cell_q <= cell_d;
  end

  assign q = cell_q;

endmodule

// File: rtl/ttt_turn_controller.sv
// Turn sequencer for the 3x3 board: alternates X (human) and O (CPU),
// validates and commits moves, times out the human, and detects win/draw.
module ttt_turn_controller
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 26
) (
  input  logic                 clock,
  input  logic                 reset,
  ttt_turn_controller_if.slave bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_d, state_q;
  cell_t              mover_d, mover_q;
  cell_t              winner_d, winner_q;
  logic [3:0]         pos_d, pos_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [1:0]         turn_d, turn_q;
  logic               cpu_req_d, cpu_req_q;
  logic               move_err_d, move_err_q;
  logic               game_over_d, game_over_q;
  logic               clr;
  logic [NCELLS-1:0]  we;
  cell_t              cells [NCELLS];
  logic [BOARD_W-1:0] board;

  for (genvar i = 0; i < NCELLS; i++) begin : g_cell
    ttt_cell u_cell (
      .clock (clock),
      .reset (reset),
      .clr   (clr),
      .we    (we[i]),
      .d     (mover_q),
      .q     (cells[i])
    );
    assign board[2*i +: 2] = cells[i];
  end

  // pos_q is always a legal empty index by the time COMMIT is reached.
  always_comb begin
    we = '0;
    for (int i = 0; i < NCELLS; i++) begin
      if (state_q == S_COMMIT && pos_q == 4'(i)) we[i] = 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    mover_d    = mover_q;
    winner_d   = winner_q;
    pos_d      = pos_q;
    move_err_d = 1'b0;
    clr        = 1'b0;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          clr      = 1'b1;
          mover_d  = PX;
          winner_d = EMPTY;
          state_d  = S_P1_WAIT;
        end
      end
      S_P1_WAIT: begin
        if (bus.move_valid && is_legal(board, bus.move_pos)) begin
          pos_d   = bus.move_pos;
          state_d = S_COMMIT;
        end else begin
          move_err_d = bus.move_valid;
          if (cnt_q == TIMEOUT_LAST) begin
            pos_d   = lowest_empty(board);
            state_d = S_COMMIT;
          end
        end
      end
      S_P2_WAIT: begin
        if (bus.cpu_valid) begin
          pos_d   = is_legal(board, bus.cpu_pos) ? bus.cpu_pos : lowest_empty(board);
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_CHECK;
      S_CHECK: begin
        if (has_line(board, mover_q)) begin
          winner_d = mover_q;
          state_d  = S_OVER;
        end else if (board_full(board)) begin
          winner_d = EMPTY;
          state_d  = S_OVER;
        end else begin
          mover_d = (mover_q == PX) ? PO : PX;
          state_d = (mover_q == PX) ? S_P2_WAIT : S_P1_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counter restarts on every entry to the human wait and saturates there.
    cnt_d = '0;
    if (state_q == S_P1_WAIT && state_d == S_P1_WAIT)
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    turn_d      = (state_d == S_P1_WAIT) ? 2'b01 :
                  (state_d == S_P2_WAIT) ? 2'b10 : 2'b00;
    cpu_req_d   = (state_d == S_P2_WAIT);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mover_q     <= PX;
      winner_q    <= EMPTY;
      pos_q       <= '0;
      cnt_q       <= '0;
      turn_q      <= 2'b00;
      cpu_req_q   <= 1'b0;
      move_err_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mover_q     <= mover_d;
      winner_q    <= winner_d;
      pos_q       <= pos_d;
      cnt_q       <= cnt_d;
      turn_q      <= turn_d;
      cpu_req_q   <= cpu_req_d;
      move_err_q  <= move_err_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.board     = board;
  assign bus.turn      = turn_q;
  assign bus.cpu_req   = cpu_req_q;
  assign bus.move_err  = move_err_q;
  assign bus.winner    = winner_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Directed bench for ttt_turn_controller: a cycle-accurate vector table for
// one X win, plus hand sequences for timeout, CPU fallback, reset and draw.
module tb_ttt_turn_controller;
  import ttt_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clock = ~clock;

  ttt_turn_controller_if bus ();

  ttt_turn_controller #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic               start;
    logic               mv;
    logic [3:0]         mpos;
    logic               cv;
    logic [3:0]         cpos;
    logic [BOARD_W-1:0] board;
    logic [1:0]         turn;
    logic               cpu_req;
    logic               move_err;
    logic               game_over;
    logic [1:0]         winner;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int st, int mv, int mp, int cv, int cp, int brd,
                              int tn, int rq, int er, int ov, int wn);
    vec_t r;
    r.start = st[0];  r.mv = mv[0];  r.mpos = 4'(mp);  r.cv = cv[0];  r.cpos = 4'(cp);
    r.board = 18'(brd);  r.turn = 2'(tn);  r.cpu_req = rq[0];  r.move_err = er[0];
    r.game_over = ov[0];  r.winner = 2'(wn);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;  bus.move_valid = 1'b0;  bus.move_pos = '0;
    bus.cpu_valid = 1'b0;  bus.cpu_pos = '0;
  endtask

  task automatic wait_turn(input logic [1:0] want, input string name);
    int n = 0;
    while (bus.turn !== want && n < 64) begin
      tick();
      n++;
    end
    check(name, 32'(bus.turn), 32'(want));
  endtask

  task automatic human(input int pos);
    wait_turn(2'b01, "wait_x_turn");
    bus.move_valid = 1'b1;
    bus.move_pos   = 4'(pos);
    tick();
    bus.move_valid = 1'b0;
  endtask

  task automatic cpu(input int pos, input int delay);
    wait_turn(2'b10, "wait_o_turn");
    repeat (delay) tick();
    bus.cpu_valid = 1'b1;
    bus.cpu_pos   = 4'(pos);
    tick();
    bus.cpu_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    repeat (3) tick();
    check("reset_board", 32'(bus.board), 32'h0);
    check("reset_turn", 32'(bus.turn), 32'h0);
    check("reset_over", 32'(bus.game_over), 32'h0);
    check("reset_req", 32'(bus.cpu_req), 32'h0);
    reset = 1'b1;

    // X wins on the top row; CPU answers 3 cycles after cpu_req; illegal and stray strobes mixed in.
    vq.push_back(mk(1, 0,  0, 0, 0, 'h00000, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 1,  0, 0, 0, 'h00000, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00001, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00001, 2, 1, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00001, 2, 1, 0, 0, 0));
    vq.push_back(mk(0, 1,  2, 0, 0, 'h00001, 2, 1, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 1, 4, 'h00001, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00201, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00201, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 1,  4, 0, 0, 'h00201, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 11, 0, 0, 'h00201, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0,  0, 1, 0, 'h00201, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 1,  1, 0, 0, 'h00201, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00205, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00205, 2, 1, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00205, 2, 1, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00205, 2, 1, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 1, 5, 'h00205, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00A05, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00A05, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1,  2, 0, 0, 'h00A05, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00A15, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 0, 'h00A15, 0, 0, 0, 1, 1));
    vq.push_back(mk(0, 1,  8, 1, 8, 'h00A15, 0, 0, 0, 1, 1));

    foreach (vq[i]) begin
      bus.start = vq[i].start;  bus.move_valid = vq[i].mv;  bus.move_pos = vq[i].mpos;
      bus.cpu_valid = vq[i].cv;  bus.cpu_pos = vq[i].cpos;
      tick();
      check($sformatf("v%0d board", i), 32'(bus.board), 32'(vq[i].board));
      check($sformatf("v%0d turn", i), 32'(bus.turn), 32'(vq[i].turn));
      check($sformatf("v%0d cpu_req", i), 32'(bus.cpu_req), 32'(vq[i].cpu_req));
      check($sformatf("v%0d move_err", i), 32'(bus.move_err), 32'(vq[i].move_err));
      check($sformatf("v%0d game_over", i), 32'(bus.game_over), 32'(vq[i].game_over));
      check($sformatf("v%0d winner", i), 32'(bus.winner), 32'(vq[i].winner));
    end
    idle_inputs();

    // Human timeout: X at 0, O at 1, then X idles and cell 2 is auto-played.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_board", 32'(bus.board), 32'h0);
    human(0);
    cpu(1, 0);
    wait_turn(2'b01, "timeout_entry");
    repeat (15) tick();
    check("timeout_not_early", 32'(bus.turn), 32'h1);
    tick();
    check("timeout_commit_turn", 32'(bus.turn), 32'h0);
    check("timeout_commit_board", 32'(bus.board), 32'h00009);
    tick();
    check("timeout_written", 32'(bus.board), 32'h00019);
    wait_turn(2'b10, "timeout_then_cpu");
    check("timeout_cpu_req", 32'(bus.cpu_req), 32'h1);

    // CPU picks an occupied cell: fallback writes the lowest empty cell (3) with O.
    cpu(0, 0);
    tick();
    tick();
    check("fallback_board", 32'(bus.board), 32'h00099);

    // Reset mid-game with a non-empty board.
    reset = 1'b0;
    tick();
    tick();
    check("midreset_board", 32'(bus.board), 32'h0);
    check("midreset_turn", 32'(bus.turn), 32'h0);
    check("midreset_over", 32'(bus.game_over), 32'h0);
    check("midreset_req", 32'(bus.cpu_req), 32'h0);
    reset = 1'b1;
    tick();
    check("idle_after_reset", 32'(bus.turn), 32'h0);

    // Draw: X 0,2,3,7,8 / O 1,4,5,6.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    human(0); cpu(1, 2); human(2); cpu(4, 0); human(3);
    cpu(5, 1); human(7); cpu(6, 0); human(8);
    tick();
    tick();
    check("draw_board", 32'(bus.board), 32'h16A59);
    check("draw_over", 32'(bus.game_over), 32'h1);
    check("draw_winner", 32'(bus.winner), 32'h0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("newgame_board", 32'(bus.board), 32'h0);
    check("newgame_turn", 32'(bus.turn), 32'h1);
    check("newgame_over", 32'(bus.game_over), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
